// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 BIST engine: FSM states, c17 net indices
// used by stuck-at injection, and default LFSR/MISR polynomials.
package c17_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int unsigned NUM_NETS = 11;

  // fault_node encoding; 11..15 select no net
  localparam int unsigned NET_N1  = 0;
  localparam int unsigned NET_N2  = 1;
  localparam int unsigned NET_N3  = 2;
  localparam int unsigned NET_N6  = 3;
  localparam int unsigned NET_N7  = 4;
  localparam int unsigned NET_N10 = 5;
  localparam int unsigned NET_N11 = 6;
  localparam int unsigned NET_N16 = 7;
  localparam int unsigned NET_N19 = 8;
  localparam int unsigned NET_N22 = 9;
  localparam int unsigned NET_N23 = 10;

  localparam logic [79:0] LFSR_SEED_DEF = 80'h00001;
  localparam logic [79:0] LFSR_POLY_DEF = 80'h90000;
  localparam logic [31:0] MISR_POLY_DEF = 32'h0000001D;

  function automatic logic [NUM_NETS-1:0] node_onehot(input logic [3:0] node);
    logic [NUM_NETS-1:0] oh;
    oh = '0;
    for (int unsigned k = 0; k < NUM_NETS; k++) begin
      if (node == 4'(k)) oh[k] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/c17_bist_engine_core.sv
// One combinational c17 lane (six NAND2) with a per-net stuck-at override on
// every primary input and internal/output net.
module c17_core
  import c17_bist_pkg::*;
(
  input  logic [4:0]          in_i,
  input  logic [NUM_NETS-1:0] force_en_i,
  input  logic [NUM_NETS-1:0] force_val_i,
  output logic [1:0]          out_o
);

  logic n1, n2, n3, n6, n7;
  logic n10, n11, n16, n19, n22, n23;

  // in_i is {N7,N6,N3,N2,N1}
  assign n1  = force_en_i[NET_N1]  ? force_val_i[NET_N1]  : in_i[0];
  assign n2  = force_en_i[NET_N2]  ? force_val_i[NET_N2]  : in_i[1];
  assign n3  = force_en_i[NET_N3]  ? force_val_i[NET_N3]  : in_i[2];
  assign n6  = force_en_i[NET_N6]  ? force_val_i[NET_N6]  : in_i[3];
  assign n7  = force_en_i[NET_N7]  ? force_val_i[NET_N7]  : in_i[4];

  assign n10 = force_en_i[NET_N10] ? force_val_i[NET_N10] : ~(n1 & n3);
  assign n11 = force_en_i[NET_N11] ? force_val_i[NET_N11] : ~(n3 & n6);
  assign n16 = force_en_i[NET_N16] ? force_val_i[NET_N16] : ~(n2 & n11);
  assign n19 = force_en_i[NET_N19] ? force_val_i[NET_N19] : ~(n11 & n7);
  assign n22 = force_en_i[NET_N22] ? force_val_i[NET_N22] : ~(n10 & n16);
  assign n23 = force_en_i[NET_N23] ? force_val_i[NET_N23] : ~(n16 & n19);

  assign out_o = {n23, n22};

endmodule

// File: rtl/c17_bist_engine.sv
// Multi-lane c17 self-test engine: LFSR pattern source, one-stage capture pipe, MISR.
// Optional stuck-at injection ports are enabled by defining C17_FAULT_INJECT_EN.
module c17_bist_engine
  import c17_bist_pkg::*;
#(
  parameter int unsigned  LANES     = 4,
  parameter int unsigned  PATTERNS  = 32,
  parameter logic [79:0]  LFSR_SEED = LFSR_SEED_DEF,
  parameter logic [79:0]  LFSR_POLY = LFSR_POLY_DEF,
  parameter logic [31:0]  MISR_POLY = MISR_POLY_DEF,
  localparam int unsigned LFSR_W    = 5 * LANES,
  localparam int unsigned MISR_W    = 2 * LANES,
  localparam int unsigned FL_W      = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MISR_W-1:0] golden_sig,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [15:0]       pattern_idx
`ifdef C17_FAULT_INJECT_EN
  ,
  input  logic              fault_en,
  input  logic [FL_W-1:0]   fault_lane,
  input  logic [3:0]        fault_node,
  input  logic              fault_val
`endif
);

  localparam logic [LFSR_W-1:0] SEED_L   = LFSR_SEED[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED_L == '0) ? LFSR_W'(1) : SEED_L;
  localparam logic [LFSR_W-1:0] POLY_L   = LFSR_POLY[LFSR_W-1:0];
  localparam logic [MISR_W-1:0] MPOLY_L  = MISR_POLY[MISR_W-1:0];
  localparam logic [15:0]       PAT_MAX  = 16'(PATTERNS);

  state_e state_q, state_d;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [MISR_W-1:0] misr_q, misr_d;
  logic [MISR_W-1:0] pipe_q, pipe_d;
  logic              vld_q, vld_d;
  logic [15:0]       idx_q, idx_d;
  logic              pass_q, pass_d;

  logic [MISR_W-1:0] outvec;
  logic [MISR_W-1:0] misr_step;
  logic [LFSR_W-1:0] lfsr_step;

  // ---------------- fault selection ----------------
  logic [NUM_NETS-1:0] lane_fen  [LANES];
  logic [NUM_NETS-1:0] lane_fval [LANES];

`ifdef C17_FAULT_INJECT_EN
  logic            fault_en_q;
  logic [FL_W-1:0] fault_lane_q;
  logic [3:0]      fault_node_q;
  logic            fault_val_q;

  // Fault controls are frozen at LOAD so a run sees one consistent fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_en_q   <= 1'b0;
      fault_lane_q <= '0;
      fault_node_q <= '0;
      fault_val_q  <= 1'b0;
    end else if (state_q == LOAD) begin
      fault_en_q   <= fault_en;
      fault_lane_q <= fault_lane;
      fault_node_q <= fault_node;
      fault_val_q  <= fault_val;
    end
  end
`endif

  // ---------------- lanes ----------------
  for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef C17_FAULT_INJECT_EN
    assign lane_fen[i]  = (fault_en_q && (fault_lane_q == FL_W'(i))) ?
                          node_onehot(fault_node_q) : '0;
    assign lane_fval[i] = {NUM_NETS{fault_val_q}};
`else
    assign lane_fen[i]  = '0;
    assign lane_fval[i] = '0;
`endif

    c17_core u_core (
      .in_i        (lfsr_q[5*i +: 5]),
      .force_en_i  (lane_fen[i]),
      .force_val_i (lane_fval[i]),
      .out_o       (outvec[2*i +: 2])
    );
  end

  assign lfsr_step = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & POLY_L)};
  assign misr_step = {misr_q[MISR_W-2:0], 1'b0}
                   ^ (misr_q[MISR_W-1] ? MPOLY_L : '0)
                   ^ pipe_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD:  state_d = RUN;
      RUN:   if (idx_q >= PAT_MAX - 16'd1) state_d = DRAIN;
      DRAIN: state_d = DONE;
      DONE:  state_d = start ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      LOAD, RUN, DRAIN: busy = 1'b1;
      DONE:             done = 1'b1;
      default:          ;
    endcase
  end

  // ---------------- datapath next state ----------------
  // vld marks that pipe holds a captured pattern, so the MISR folds one cycle behind capture.
  always_comb begin
    lfsr_d = lfsr_q;
    misr_d = misr_q;
    pipe_d = pipe_q;
    vld_d  = vld_q;
    idx_d  = idx_q;
    pass_d = pass_q;
    unique case (state_q)
      LOAD: begin
        lfsr_d = SEED_EFF;
        misr_d = '0;
        pipe_d = '0;
        vld_d  = 1'b0;
        idx_d  = '0;
        pass_d = 1'b0;
      end
      RUN: begin
        pipe_d = outvec;
        vld_d  = 1'b1;
        lfsr_d = lfsr_step;
        if (idx_q < PAT_MAX) idx_d = idx_q + 16'd1;
        if (vld_q) misr_d = misr_step;
      end
      DRAIN: begin
        if (vld_q) misr_d = misr_step;
        vld_d = 1'b0;
      end
      DONE: pass_d = (misr_q == golden_sig);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED_EFF;
      misr_q <= '0;
      pipe_q <= '0;
      vld_q  <= 1'b0;
      idx_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      misr_q <= misr_d;
      pipe_q <= pipe_d;
      vld_q  <= vld_d;
      idx_q  <= idx_d;
      pass_q <= pass_d;
    end
  end

  assign pass        = pass_q;
  assign signature   = misr_q;
  assign pattern_idx = idx_q;

endmodule

// File: tb/tb_c17_bist_engine.sv
// Self-checking bench for c17_bist_engine: default 4-lane engine plus two 1-lane,
// 1-pattern instances, checked against a behavioural signature model.
module tb_c17_bist_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // default instance
  logic       start0 = 1'b0;
  logic [7:0] gold0  = '0;
  logic       busy0, done0, pass0;
  logic [7:0] sig0;
  logic [15:0] idx0;

  // 1 lane, 1 pattern, seed 5'b11111
  logic       start1 = 1'b0;
  logic [1:0] gold1  = '0;
  logic       busy1, done1, pass1;
  logic [1:0] sig1;
  logic [15:0] idx1;

  // 1 lane, 1 pattern, seed 5'b00001
  logic       start2 = 1'b0;
  logic [1:0] gold2  = '0;
  logic       busy2, done2, pass2;
  logic [1:0] sig2;
  logic [15:0] idx2;

`ifdef C17_FAULT_INJECT_EN
  logic       f_en   = 1'b0;
  logic       f_lane = 1'b0;
  logic [3:0] f_node = 4'hF;
  logic       f_val  = 1'b0;
`endif

  c17_bist_engine u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .golden_sig(gold0),
    .busy(busy0), .done(done0), .pass(pass0), .signature(sig0), .pattern_idx(idx0)
`ifdef C17_FAULT_INJECT_EN
    , .fault_en(1'b0), .fault_lane(2'b00), .fault_node(4'hF), .fault_val(1'b0)
`endif
  );

  c17_bist_engine #(.LANES(1), .PATTERNS(1), .LFSR_SEED(80'h1F)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .golden_sig(gold1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .pattern_idx(idx1)
`ifdef C17_FAULT_INJECT_EN
    , .fault_en(f_en), .fault_lane(f_lane), .fault_node(f_node), .fault_val(f_val)
`endif
  );

  c17_bist_engine #(.LANES(1), .PATTERNS(1), .LFSR_SEED(80'h01)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .golden_sig(gold2),
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .pattern_idx(idx2)
`ifdef C17_FAULT_INJECT_EN
    , .fault_en(1'b0), .fault_lane(1'b0), .fault_node(4'hF), .fault_val(1'b0)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [1:0] c17_ref(input logic [4:0] v);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19, n22, n23;
    {n7, n6, n3, n2, n1} = v;
    n10 = !(n1 && n3);
    n11 = !(n3 && n6);
    n16 = !(n2 && n11);
    n19 = !(n11 && n7);
    n22 = !(n10 && n16);
    n23 = !(n16 && n19);
    return {n23, n22};
  endfunction

  // Signature after folding every pattern's lane outputs, in order, into a zeroed MISR.
  function automatic logic [31:0] ref_sig(input int lanes, input int pats,
                                          input logic [79:0] seed, input logic [79:0] poly,
                                          input logic [31:0] mpoly);
    int lw = 5 * lanes;
    int mw = 2 * lanes;
    logic [79:0] lmask, lfsr;
    logic [63:0] t;
    logic [31:0] mmask, misr, outv;
    logic fb, msb;
    lmask = (80'd1 << lw) - 80'd1;
    t = (64'd1 << mw) - 64'd1;
    mmask = t[31:0];
    lfsr = seed & lmask;
    if (lfsr == 80'd0) lfsr = 80'd1;
    misr = 32'd0;
    for (int k = 0; k < pats; k++) begin
      outv = 32'd0;
      for (int i = 0; i < lanes; i++)
        outv = outv | (32'(c17_ref(5'(lfsr >> (5 * i)))) << (2 * i));
      fb = ^(lfsr & poly & lmask);
      lfsr = ((lfsr << 1) | {79'd0, fb}) & lmask;
      msb = misr[mw-1];
      misr = ((misr << 1) & mmask) ^ (msb ? (mpoly & mmask) : 32'd0) ^ outv;
    end
    return misr;
  endfunction

  logic [7:0] exp0;

  // pulse start on instance 0, then count busy cycles until done (bounded)
  task automatic run0(output int busy_cycles, output bit got_done);
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 200 && !done0; c++) begin
      if (busy0) busy_cycles++;
      @(negedge clk);
    end
    got_done = done0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done0); end
    checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", pass0); end
    checks++; if (sig0 !== 8'h00) begin errors++; $display("FAIL reset_sig got=%h exp=00", sig0); end
    checks++; if (idx0 !== 16'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", idx0); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_lane();
    int bc;
    gold1 = 2'b01;
    gold2 = 2'b01;
    @(negedge clk) begin start1 = 1'b1; start2 = 1'b1; end
    @(negedge clk) begin start1 = 1'b0; start2 = 1'b0; end
    bc = 0;
    for (int c = 0; c < 50 && !done1; c++) begin
      if (busy1) bc++;
      @(negedge clk);
    end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL l1_done got=%b exp=1", done1); end
    checks++; if (bc != 3) begin errors++; $display("FAIL l1_busy_cycles got=%0d exp=3", bc); end
    checks++; if (idx1 !== 16'd1) begin errors++; $display("FAIL l1_idx got=%0d exp=1", idx1); end
    checks++; if (sig1 !== 2'b01) begin errors++; $display("FAIL l1_sig_ones got=%b exp=01", sig1); end
    checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL l1b_done got=%b exp=1", done2); end
    checks++; if (sig2 !== 2'b00) begin errors++; $display("FAIL l1_sig_seed1 got=%b exp=00", sig2); end
    @(negedge clk);
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL l1_done_pulse got=%b exp=0", done1); end
    checks++; if (pass1 !== 1'b1) begin errors++; $display("FAIL l1_pass_ones got=%b exp=1", pass1); end
    checks++; if (pass2 !== 1'b0) begin errors++; $display("FAIL l1_pass_seed1 got=%b exp=0", pass2); end
  endtask

  task automatic test_default_run();
    int bc;
    bit gd;
    logic exp_pass;
    for (int r = 0; r < 4; r++) begin
      gold0 = ($urandom_range(0, 1) == 1) ? exp0 : 8'($urandom);
      exp_pass = (gold0 == exp0);
      run0(bc, gd);
      checks++; if (!gd) begin errors++; $display("FAIL run%0d_done_timeout got=%b exp=1", r, gd); end
      checks++; if (bc != 34) begin errors++; $display("FAIL run%0d_busy_cycles got=%0d exp=34", r, bc); end
      checks++; if (idx0 !== 16'd32) begin errors++; $display("FAIL run%0d_idx got=%0d exp=32", r, idx0); end
      checks++; if (sig0 !== exp0) begin errors++; $display("FAIL run%0d_sig got=%h exp=%h", r, sig0, exp0); end
      @(negedge clk);
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL run%0d_done_pulse got=%b exp=0", r, done0); end
      checks++; if (pass0 !== exp_pass) begin errors++; $display("FAIL run%0d_pass got=%b exp=%b", r, pass0, exp_pass); end
      checks++; if (sig0 !== exp0) begin errors++; $display("FAIL run%0d_sig_hold got=%h exp=%h", r, sig0, exp0); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    int bc;
    bit gd;
    bit saw_done;
    gold0 = exp0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b exp=1", busy0); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy0); end
    checks++; if (sig0 !== 8'h00) begin errors++; $display("FAIL abort_sig got=%h exp=00", sig0); end
    checks++; if (idx0 !== 16'd0) begin errors++; $display("FAIL abort_idx got=%0d exp=0", idx0); end
    checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL abort_pass got=%b exp=0", pass0); end
    saw_done = 1'b0;
    repeat (3) begin @(negedge clk); if (done0 !== 1'b0) saw_done = 1'b1; end
    rst_n = 1'b1;
    repeat (40) begin @(negedge clk); if (done0 !== 1'b0) saw_done = 1'b1; end
    checks++; if (saw_done) begin errors++; $display("FAIL abort_no_done got=1 exp=0"); end
    run0(bc, gd);
    checks++; if (!gd) begin errors++; $display("FAIL rerun_done_timeout got=%b exp=1", gd); end
    checks++; if (sig0 !== exp0) begin errors++; $display("FAIL rerun_sig got=%h exp=%h", sig0, exp0); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int bc;
    gold0 = exp0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk);
    for (int run = 0; run < 2; run++) begin
      bc = 0;
      for (int c = 0; c < 200 && !done0; c++) begin
        if (busy0) bc++;
        @(negedge clk);
      end
      if (run == 1) start0 = 1'b0;
      checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL b2b%0d_done_timeout got=%b exp=1", run, done0); end
      checks++; if (bc != 34) begin errors++; $display("FAIL b2b%0d_busy_cycles got=%0d exp=34", run, bc); end
      checks++; if (sig0 !== exp0) begin errors++; $display("FAIL b2b%0d_sig got=%h exp=%h", run, sig0, exp0); end
      @(negedge clk);
      checks++; if (pass0 !== 1'b1) begin errors++; $display("FAIL b2b%0d_pass got=%b exp=1", run, pass0); end
      checks++; if (busy0 !== (run == 0)) begin errors++; $display("FAIL b2b%0d_restart got=%b exp=%b", run, busy0, run == 0); end
    end
  endtask

`ifdef C17_FAULT_INJECT_EN
  task automatic test_fault_inject();
    gold1 = 2'b01;
    f_en = 1'b1; f_lane = 1'b0; f_node = 4'd9; f_val = 1'b0;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    for (int c = 0; c < 50 && !done1; c++) @(negedge clk);
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL fault_done got=%b exp=1", done1); end
    checks++; if (sig1 !== 2'b00) begin errors++; $display("FAIL fault_sig got=%b exp=00", sig1); end
    @(negedge clk);
    checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL fault_pass got=%b exp=0", pass1); end
    f_en = 1'b0; f_node = 4'hF;
  endtask
`endif

  initial begin
    exp0 = 8'(ref_sig(4, 32, 80'h00001, 80'h90000, 32'h1D));
    test_reset();
    test_single_lane();
    test_default_run();
    test_reset_abort();
    test_back_to_back();
`ifdef C17_FAULT_INJECT_EN
    test_fault_inject();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
